// File: rtl/mine_pkg.sv
// Shared types and constants for the mine board reader.
package mine_pkg;

    localparam int unsigned MAX_DIM = 16;
    localparam int unsigned COORD_W = $clog2(MAX_DIM);

    // Width of the runtime board-edge input (must hold MAX_DIM itself).
    localparam int unsigned DIM_W = 5;

    // Scan index: 0 is the centre cell, 1..8 are the neighbours.
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned IDX_LAST = 8;

    // Difficulty board edges.
    localparam logic [DIM_W-1:0] DIM_EASY   = 5'd8;
    localparam logic [DIM_W-1:0] DIM_MEDIUM = 5'd10;
    localparam logic [DIM_W-1:0] DIM_HARD   = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic signed [1:0] offset_t;

    // Neighbour visiting order, row above first, then same row, then row below.
    localparam offset_t NB_DX [8] = '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
    localparam offset_t NB_DY [8] = '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

    // Column offset for scan index k (index 0 is the centre, offset 0).
    function automatic offset_t nb_dx(input logic [IDX_W-1:0] k);
        if (k == '0) begin
            return 2'sd0;
        end
        return NB_DX[3'(k - 4'd1)];
    endfunction

    // Row offset for scan index k (index 0 is the centre, offset 0).
    function automatic offset_t nb_dy(input logic [IDX_W-1:0] k);
        if (k == '0) begin
            return 2'sd0;
        end
        return NB_DY[3'(k - 4'd1)];
    endfunction

endpackage

// File: rtl/mine_neighbour_counter_addr_gen.sv
// Combinational neighbour address generator: centre + table offset,
// with a bounds flag instead of wrapping at the board edge.
module neighbour_addr_gen #(
    parameter int unsigned COORD_W = 4
) (
    input  logic [COORD_W-1:0]        cx,
    input  logic [COORD_W-1:0]        cy,
    input  logic [mine_pkg::IDX_W-1:0] k,
    input  logic [mine_pkg::DIM_W-1:0] dim,
    output logic [COORD_W-1:0]        rd_x,
    output logic [COORD_W-1:0]        rd_y,
    output logic                      in_bounds
);
    import mine_pkg::*;

    // Two extra bits: one for the +1 carry, one for the sign of -1 at zero.
    logic signed [COORD_W+1:0] nx;
    logic signed [COORD_W+1:0] ny;
    logic                      x_ok;
    logic                      y_ok;

    // Offset the centre and classify the result against the live board edge.
    always_comb begin
        nx        = signed'({2'b00, cx}) + (COORD_W+2)'(nb_dx(k));
        ny        = signed'({2'b00, cy}) + (COORD_W+2)'(nb_dy(k));
        x_ok      = !nx[COORD_W+1] && (32'(nx) < 32'(dim));
        y_ok      = !ny[COORD_W+1] && (32'(ny) < 32'(dim));
        in_bounds = x_ok && y_ok;
        rd_x      = nx[COORD_W-1:0];
        rd_y      = ny[COORD_W-1:0];
    end

endmodule

// File: rtl/mine_neighbour_counter.sv
// Cell query engine: reads the centre cell and its 8 neighbours through the
// board's one-cycle-latency read port and reports mine flag + neighbour count.
module mine_neighbour_counter #(
    parameter int unsigned MAX_DIM = 16,
    parameter int unsigned COORD_W = $clog2(MAX_DIM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         dimension_size,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    output logic               rd_en,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic               rd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_mine,
    output logic [3:0]         rsp_count,
    output logic               rsp_err,
    output logic [COORD_W-1:0] rsp_x,
    output logic [COORD_W-1:0] rsp_y
);
    import mine_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   k_q;
    logic [DIM_W-1:0]   dim_q;
    logic               accept;
    logic               out_of_range;
    logic               scan_last;
    logic               rsp_done;
    logic [COORD_W-1:0] ag_x;
    logic [COORD_W-1:0] ag_y;
    logic               ag_in;
    logic               rd_en_d;
    logic               centre_q;
    logic               centre_d;

    assign req_ready    = (state_q == IDLE);
    assign accept       = req_valid && req_ready;
    assign out_of_range = (32'(req_x) >= 32'(dimension_size)) ||
                          (32'(req_y) >= 32'(dimension_size));
    assign scan_last    = (state_q == SCAN) && (k_q == IDX_W'(IDX_LAST));
    assign rsp_done     = rsp_valid && rsp_ready;

    // The latched query coordinates double as the echoed response fields.
    neighbour_addr_gen #(
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .cx        (rsp_x),
        .cy        (rsp_y),
        .k         (k_q),
        .dim       (dim_q),
        .rd_x      (ag_x),
        .rd_y      (ag_y),
        .in_bounds (ag_in)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = out_of_range ? RESP : SCAN;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Query latch, read issue, read-data accumulation and response handshake.
    // The read pipeline is two stages deep (registered rd_en, then board
    // latency), so RESP is entered one cycle before the last read data lands;
    // rsp_valid rises on the edge after entering RESP, which lines up with
    // that final accumulation and gives the error path the same one-edge rule.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q       <= '0;
            dim_q     <= '0;
            rd_en     <= 1'b0;
            rd_x      <= '0;
            rd_y      <= '0;
            rd_en_d   <= 1'b0;
            centre_q  <= 1'b0;
            centre_d  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_mine  <= 1'b0;
            rsp_count <= '0;
            rsp_err   <= 1'b0;
            rsp_x     <= '0;
            rsp_y     <= '0;
        end else begin
            if (accept) begin
                rsp_x     <= req_x;
                rsp_y     <= req_y;
                dim_q     <= dimension_size;
                rsp_err   <= out_of_range;
                rsp_mine  <= 1'b0;
                rsp_count <= '0;
                k_q       <= '0;
            end else if (state_q == SCAN) begin
                k_q <= k_q + 1'b1;
            end

            rd_en    <= (state_q == SCAN) && ag_in;
            rd_x     <= ((state_q == SCAN) && ag_in) ? ag_x : '0;
            rd_y     <= ((state_q == SCAN) && ag_in) ? ag_y : '0;
            centre_q <= (state_q == SCAN) && (k_q == '0);
            rd_en_d  <= rd_en;
            centre_d <= centre_q;

            if (rd_en_d && rd_data) begin
                if (centre_d) begin
                    rsp_mine <= 1'b1;
                end else begin
                    rsp_count <= rsp_count + 4'd1;
                end
            end

            if (state_q == RESP) begin
                if (!rsp_valid) begin
                    rsp_valid <= 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mine_neighbour_counter.sv
// Directed self-checking bench for mine_neighbour_counter with a simple
// synchronous-read board model.
module tb_mine_neighbour_counter;

    logic       clk;
    logic       rst;
    logic [4:0] dimension_size;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_x;
    logic [3:0] req_y;
    logic       rd_en;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic       rd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_mine;
    logic [3:0] rsp_count;
    logic       rsp_err;
    logic [3:0] rsp_x;
    logic [3:0] rsp_y;

    int n_checks = 0;
    int n_fail   = 0;

    logic mines [16][16];
    int   reads     = 0;
    int   bad_reads = 0;
    int   mon_qx    = 0;
    int   mon_qy    = 0;
    int   mon_dim   = 16;

    mine_neighbour_counter #(
        .MAX_DIM (16),
        .COORD_W (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dimension_size (dimension_size),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_x          (req_x),
        .req_y          (req_y),
        .rd_en          (rd_en),
        .rd_x           (rd_x),
        .rd_y           (rd_y),
        .rd_data        (rd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_mine       (rsp_mine),
        .rsp_count      (rsp_count),
        .rsp_err        (rsp_err),
        .rsp_x          (rsp_x),
        .rsp_y          (rsp_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board: data one cycle after rd_en; drives 1 when not read so that
    // unqualified data would be counted.
    always @(posedge clk) begin
        rd_data <= rd_en ? mines[rd_y][rd_x] : 1'b1;
    end

    // Read monitor: counts reads and any read outside the query's 3x3 window
    // or outside the board.
    always @(posedge clk) begin
        if (rd_en) begin
            reads <= reads + 1;
            if (int'(rd_x) >= mon_dim || int'(rd_y) >= mon_dim ||
                int'(rd_x) > mon_qx + 1 || int'(rd_x) + 1 < mon_qx ||
                int'(rd_y) > mon_qy + 1 || int'(rd_y) + 1 < mon_qy) begin
                bad_reads <= bad_reads + 1;
            end
        end
    end

    task automatic clear_mines();
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                mines[y][x] = 1'b0;
            end
        end
    endtask

    // Issue one query, then wait (bounded) for rsp_valid; lat is edges after accept.
    task automatic run_query(input int x, input int y, input int dim,
                             output int lat, output int nreads, output int nbad);
        int r0;
        int b0;
        mon_qx = x;
        mon_qy = y;
        mon_dim = dim;
        @(negedge clk);
        req_x = 4'(x);
        req_y = 4'(y);
        dimension_size = 5'(dim);
        req_valid = 1'b1;
        r0 = reads;
        b0 = bad_reads;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dimension_size = (dim == 8) ? 5'd16 : 5'd8;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 40);
        nreads = reads - r0;
        nbad = bad_reads - b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat, nr, nb;
        logic seen;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", rd_en); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %0b expected 1", req_ready); end

        // Abort a query part-way through the scan.
        clear_mines();
        mines[2][2] = 1'b1;
        mines[3][3] = 1'b1;
        mon_qx = 2; mon_qy = 2; mon_dim = 8;
        req_x = 4'd2; req_y = 4'd2; dimension_size = 5'd8; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL scan_req_ready: got %0b expected 0", req_ready); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL scan5_rd_en: got %0b expected 1", rd_en); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_rd_en: got %0b expected 0", rd_en); end
        n_checks++; if (rsp_x !== 4'd0 || rsp_y !== 4'd0) begin n_fail++; $display("FAIL abort_rsp_xy: got %0d,%0d expected 0,0", rsp_x, rsp_y); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_req_ready: got %0b expected 1", req_ready); end
        n_checks++; if (rd_x !== 4'd0 || rsp_count !== 4'd0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_regs: rd_x %0d count %0d valid %0b expected 0 0 0", rd_x, rsp_count, rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got %0b expected 0", seen); end

        run_query(2, 2, 8, lat, nr, nb);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 11", lat); end
        n_checks++; if (rsp_mine !== 1'b1) begin n_fail++; $display("FAIL post_reset_mine: got %0b expected 1", rsp_mine); end
        n_checks++; if (rsp_count !== 4'd1) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 1", rsp_count); end
        n_checks++; if (nr !== 9) begin n_fail++; $display("FAIL post_reset_reads: got %0d expected 9", nr); end
        finish_rsp();
    endtask

    task automatic test_corner();
        int lat, nr, nb;
        clear_mines();
        mines[1][0] = 1'b1;
        mines[0][1] = 1'b1;
        mines[1][1] = 1'b1;
        run_query(0, 0, 8, lat, nr, nb);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL corner_latency: got %0d expected 11", lat); end
        n_checks++; if (nr !== 4) begin n_fail++; $display("FAIL corner_reads: got %0d expected 4", nr); end
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL corner_bad_reads: got %0d expected 0", nb); end
        n_checks++; if (rsp_count !== 4'd3) begin n_fail++; $display("FAIL corner_count: got %0d expected 3", rsp_count); end
        n_checks++; if (rsp_mine !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL corner_mine_err: got %0b %0b expected 0 0", rsp_mine, rsp_err); end
        finish_rsp();
    endtask

    task automatic test_full_interior();
        int lat, nr, nb;
        clear_mines();
        for (int y = 4; y <= 6; y++) begin
            for (int x = 4; x <= 6; x++) begin
                mines[y][x] = 1'b1;
            end
        end
        run_query(5, 5, 10, lat, nr, nb);
        n_checks++; if (nr !== 9) begin n_fail++; $display("FAIL interior_reads: got %0d expected 9", nr); end
        n_checks++; if (rsp_count !== 4'd8) begin n_fail++; $display("FAIL interior_count: got %0d expected 8", rsp_count); end
        n_checks++; if (rsp_mine !== 1'b1) begin n_fail++; $display("FAIL interior_mine: got %0b expected 1", rsp_mine); end
        n_checks++; if (rsp_x !== 4'd5 || rsp_y !== 4'd5) begin n_fail++; $display("FAIL interior_echo: got %0d,%0d expected 5,5", rsp_x, rsp_y); end
        finish_rsp();
    endtask

    task automatic test_out_of_range();
        int lat, nr, nb;
        run_query(8, 3, 8, lat, nr, nb);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL oor_latency: got %0d expected 1", lat); end
        n_checks++; if (nr !== 0) begin n_fail++; $display("FAIL oor_reads: got %0d expected 0", nr); end
        n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %0b expected 1", rsp_err); end
        n_checks++; if (rsp_count !== 4'd0 || rsp_mine !== 1'b0) begin n_fail++; $display("FAIL oor_fields: count %0d mine %0b expected 0 0", rsp_count, rsp_mine); end
        n_checks++; if (rsp_x !== 4'd8 || rsp_y !== 4'd3) begin n_fail++; $display("FAIL oor_echo: got %0d,%0d expected 8,3", rsp_x, rsp_y); end
        finish_rsp();
    endtask

    task automatic test_far_corner();
        int lat, nr, nb;
        clear_mines();
        mines[14][14] = 1'b1;
        mines[0][0] = 1'b1;
        mines[0][15] = 1'b1;
        mines[15][0] = 1'b1;
        run_query(15, 15, 16, lat, nr, nb);
        n_checks++; if (rsp_count !== 4'd1) begin n_fail++; $display("FAIL far_count: got %0d expected 1", rsp_count); end
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL far_wrapped_reads: got %0d expected 0", nb); end
        n_checks++; if (nr !== 4) begin n_fail++; $display("FAIL far_reads: got %0d expected 4", nr); end
        n_checks++; if (rsp_err !== 1'b0 || lat !== 11) begin n_fail++; $display("FAIL far_err_latency: err %0b lat %0d expected 0 11", rsp_err, lat); end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        int lat, nr, nb, r0;
        logic stable, rdy_low;
        clear_mines();
        mines[3][2] = 1'b1;
        mines[4][4] = 1'b1;
        mines[7][7] = 1'b1;
        run_query(3, 3, 8, lat, nr, nb);
        n_checks++; if (rsp_count !== 4'd2 || rsp_mine !== 1'b0) begin n_fail++; $display("FAIL bp_first_result: count %0d mine %0b expected 2 0", rsp_count, rsp_mine); end
        req_x = 4'd6; req_y = 4'd6; dimension_size = 5'd8; req_valid = 1'b1;
        r0 = reads;
        stable = 1'b1;
        rdy_low = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_count !== 4'd2 || rsp_x !== 4'd3 || rsp_y !== 4'd3 || rsp_err !== 1'b0) stable = 1'b0;
            if (req_ready !== 1'b0) rdy_low = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_fields_stable: got %0b expected 1", stable); end
        n_checks++; if (rdy_low !== 1'b1) begin n_fail++; $display("FAIL bp_req_ready_low: got %0b expected 1", rdy_low); end
        n_checks++; if (reads - r0 !== 0) begin n_fail++; $display("FAIL bp_no_reads: got %0d expected 0", reads - r0); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_handshake: valid %0b ready %0b expected 0 1", rsp_valid, req_ready); end
        n_checks++; if (rsp_x !== 4'd3) begin n_fail++; $display("FAIL bp_not_yet_accepted: rsp_x %0d expected 3", rsp_x); end
        mon_qx = 6; mon_qy = 6; mon_dim = 8;
        r0 = reads;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0 || rsp_x !== 4'd6) begin n_fail++; $display("FAIL bp_second_accept: ready %0b rsp_x %0d expected 0 6", req_ready, rsp_x); end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 40);
        n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL bp_second_latency: got %0d expected 11", lat); end
        n_checks++; if (rsp_count !== 4'd1 || rsp_mine !== 1'b0) begin n_fail++; $display("FAIL bp_second_result: count %0d mine %0b expected 1 0", rsp_count, rsp_mine); end
        n_checks++; if (reads - r0 !== 9) begin n_fail++; $display("FAIL bp_second_reads: got %0d expected 9", reads - r0); end
        finish_rsp();
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0;
        req_x = '0;
        req_y = '0;
        dimension_size = 5'd8;
        rsp_ready = 1'b0;
        clear_mines();
        test_reset();
        test_corner();
        test_full_interior();
        test_out_of_range();
        test_far_corner();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
